// File: rtl/uc_mem_pkg.sv
// rtl/uc_mem_pkg.sv - shared constants for the microcontroller data memory
// Holds the clear-sequencer state encoding, the collision mode codes and
// the default word/address widths of the 8-bit microcontroller.
package uc_mem_pkg;

    localparam int UC_DATA_W = 8;
    localparam int UC_ADDR_W = 6;

    // Clear-sequencer states; one bit is enough for two states.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // Same-address read/write collision behaviour.
    localparam int MODE_RD_FIRST = 0;
    localparam int MODE_WR_FIRST = 1;

endpackage

// File: rtl/sram_clr_fsm.sv
// rtl/sram_clr_fsm.sv - clear sweep sequencer for the data SRAM
// Ports:
//   clk, arst        clock, asynchronous active-high reset
//   clk_valid        clock-enable qualifier for every state change
//   clr_req          one-cycle request to start a new sweep (ignored while sweeping)
//   busy             sweep in progress; also the clear write enable
//   clr_done         one qualified-cycle pulse after the final clear write
//   clr_ptr          address being cleared this cycle
module sram_clr_fsm
    import uc_mem_pkg::*;
#(
    parameter int ADDR_W = UC_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              clk_valid,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] clr_ptr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [0:0] state;

    // Reset lands in CLEAR so the array is swept after every reset release.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= ST_CLEAR;
            clr_ptr  <= '0;
            clr_done <= 1'b0;
        end else if (clk_valid) begin
            clr_done <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (clr_ptr == LAST_ADDR) begin
                        state    <= ST_IDLE;
                        clr_ptr  <= '0;
                        clr_done <= 1'b1;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (clr_req) begin
                        state   <= ST_CLEAR;
                        clr_ptr <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_CLEAR);

endmodule

// File: rtl/sram_dp_clr.sv
// rtl/sram_dp_clr.sv - dual-port data SRAM with registered reads and clear sweep
// Ports:
//   clk, arst                  clock, asynchronous active-high reset
//   clk_valid                  clock-enable qualifier for all state
//   clr_req                    start a clear sweep (IDLE only)
//   a_en/a_we/a_addr/a_wdata   port A read/write request
//   a_rdata/a_rvalid           port A registered read result
//   b_en/b_addr                port B read request
//   b_rdata/b_rvalid           port B registered read result
//   busy                       clear sweep in progress
//   clr_done                   pulse when a sweep completes
module sram_dp_clr
    import uc_mem_pkg::*;
#(
    parameter int                DATA_W   = UC_DATA_W,
    parameter int                ADDR_W   = UC_ADDR_W,
    parameter int                DEPTH    = 2 ** ADDR_W,
    parameter int                WR_FIRST = MODE_RD_FIRST,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              clk_valid,
    input  logic              clr_req,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_en,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
    output logic              busy,
    output logic              clr_done
);

    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam bit              WR_FIRST_MODE = (WR_FIRST == MODE_WR_FIRST);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] clr_ptr;
    logic              a_in_range;
    logic              b_in_range;
    logic              a_wr;
    logic [DATA_W-1:0] a_rd_next;
    logic [DATA_W-1:0] b_rd_next;

    sram_clr_fsm #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fsm (
        .clk       (clk),
        .arst      (arst),
        .clk_valid (clk_valid),
        .clr_req   (clr_req),
        .busy      (busy),
        .clr_done  (clr_done),
        .clr_ptr   (clr_ptr)
    );

    assign a_in_range = ({1'b0, a_addr} < DEPTH_L);
    assign b_in_range = ({1'b0, b_addr} < DEPTH_L);

    // Port A writes only land outside a sweep and inside the array.
    assign a_wr = a_en & a_we & ~busy & a_in_range;

    // Read data selection: a sweep masks the array with CLR_VAL, holes above
    // DEPTH read as zero, and write-first mode forwards the port A write data.
    always_comb begin
        a_rd_next = '0;
        if (busy) begin
            a_rd_next = CLR_VAL;
        end else if (a_in_range) begin
            if (WR_FIRST_MODE && a_wr) a_rd_next = a_wdata;
            else                       a_rd_next = mem[a_addr];
        end
    end

    always_comb begin
        b_rd_next = '0;
        if (busy) begin
            b_rd_next = CLR_VAL;
        end else if (b_in_range) begin
            if (WR_FIRST_MODE && a_wr && (a_addr == b_addr)) b_rd_next = a_wdata;
            else                                             b_rd_next = mem[b_addr];
        end
    end

    // Array has no reset so it maps onto block RAM; the sweep clears it.
    // Single write port: the clear write wins over port A.
    always_ff @(posedge clk) begin
        if (clk_valid) begin
            if (busy) begin
                mem[clr_ptr] <= CLR_VAL;
            end else if (a_wr) begin
                mem[a_addr] <= a_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            a_rdata  <= '0;
            a_rvalid <= 1'b0;
            b_rdata  <= '0;
            b_rvalid <= 1'b0;
        end else if (clk_valid) begin
            a_rvalid <= a_en;
            b_rvalid <= b_en;
            if (a_en) a_rdata <= a_rd_next;
            if (b_en) b_rdata <= b_rd_next;
        end
    end

endmodule
